// File: rtl/access_req_queue_if.sv
// access_req_queue_if: requester/tree-leaf signal bundle for access_req_queue.
// The master side is the requester plus the tree leaf that services the
// queue; the slave side is the queue itself.
// Handshake: a word moves in on a clock edge where push=1 and the queue
// accepts it (not full, or a pop happens on the same edge). The head moves
// out on a clock edge where req=1 and serv=1. serv with req=0 is an
// underflow, and push while full without a pop is an overflow. Both are
// recorded in sticky flags.
interface access_req_queue_if #(
  parameter int data_width = 132,
  parameter int depth      = 4
);
  localparam int CW = $clog2(depth) + 1;

  logic                  push;
  logic [data_width-1:0] data_IN;
  logic                  full;
  logic                  req;
  logic [data_width-1:0] data_OUT;
  logic                  serv;
  logic [CW-1:0]         count;
  logic                  ovf_err;
  logic                  udf_err;
  logic                  starve;

  modport master (
    output push, data_IN, serv,
    input  full, req, data_OUT, count, ovf_err, udf_err, starve
  );

  modport slave (
    input  push, data_IN, serv,
    output full, req, data_OUT, count, ovf_err, udf_err, starve
  );
endinterface

// File: rtl/access_req_queue.sv
// access_req_queue: per-requester FIFO in front of one leaf of the access
// scheduler tree. It keeps requests in order across arbitration conflicts and
// presents the head entry as a req/data pair.
// Optional head-age monitor: define ACCESS_REQ_QUEUE_AGE_MON_EN to build the
// starvation detector. Without it, starve is tied to 0.
module access_req_queue #(
  parameter int data_width = 132,
  parameter int depth      = 4
`ifdef ACCESS_REQ_QUEUE_AGE_MON_EN
  , parameter int age_limit = 15
`endif
) (
  input  logic              clk,
  input  logic              rst,
  access_req_queue_if.slave q
);
  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);

  logic [data_width-1:0] mem [depth];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic not_empty;
  logic pop;
  logic push_ok;

  assign not_empty = (count_q != '0);
  assign pop       = q.serv && not_empty;
  // A full queue still accepts a word when the head leaves on the same edge.
  assign push_ok   = q.push && ((count_q != DEPTH_C) || pop);

  // Next-state for the pointers, occupancy and sticky error flags.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CW'(1);
    end
    if (q.push && !push_ok) begin
      ovf_d = 1'b1;
    end
    if (q.serv && !not_empty) begin
      udf_d = 1'b1;
    end
  end

  // Control state register. Reset discards every entry at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage write. The contents need no reset because data_OUT is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= q.data_IN;
    end
  end

`ifdef ACCESS_REQ_QUEUE_AGE_MON_EN
  localparam int AW = $clog2(age_limit + 1) + 1;
  localparam logic [AW-1:0] AGE_MAX = '1;
  localparam logic [AW-1:0] AGE_LIM = AW'(age_limit);

  logic [AW-1:0] age_q, age_d;
  logic          starve_q, starve_d;

  // Age the head while it waits unserviced. A pop or an empty queue restarts the count.
  always_comb begin
    age_d    = age_q;
    starve_d = starve_q;
    if (pop || !not_empty) begin
      age_d    = '0;
      starve_d = 1'b0;
    end else if (!q.serv) begin
      if (age_q != AGE_MAX) begin
        age_d = age_q + AW'(1);
      end
      if (age_d >= AGE_LIM) begin
        starve_d = 1'b1;
      end
    end
  end

  // Age counter and registered starvation flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_q    <= '0;
      starve_q <= 1'b0;
    end else begin
      age_q    <= age_d;
      starve_q <= starve_d;
    end
  end

  assign q.starve = starve_q;
`else
  assign q.starve = 1'b0;
`endif

  assign q.req      = not_empty;
  assign q.data_OUT = not_empty ? mem[rd_ptr_q] : '0;
  assign q.full     = (count_q == DEPTH_C);
  assign q.count    = count_q;
  assign q.ovf_err  = ovf_q;
  assign q.udf_err  = udf_q;
endmodule

// File: tb/tb_access_req_queue.sv
// tb_access_req_queue: directed scoreboard bench for access_req_queue.
// The driver pushes the expected word into exp_q whenever it issues a push
// that must be accepted. The monitor pops exp_q and compares it on every
// cycle where the tree takes the head (req=1, serv=1).
module tb_access_req_queue;
  localparam int DW    = 132;
  localparam int DEPTH = 4;
`ifdef ACCESS_REQ_QUEUE_AGE_MON_EN
  localparam bit AGE_ON = 1'b1;
`else
  localparam bit AGE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [DW-1:0] exp_q[$];

  access_req_queue_if #(.data_width(DW), .depth(DEPTH)) dut_if();

  access_req_queue #(.data_width(DW), .depth(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (dut_if)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  // Request word: the byte tag sits at both ends, so both halves of the bus are exercised.
  function automatic logic [DW-1:0] w(input logic [7:0] b);
    return {b, {(DW-16){1'b0}}, b};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus. acc marks a push that must be accepted.
  task automatic cyc(input logic p, input logic [DW-1:0] d, input logic s, input logic acc);
    dut_if.push    = p;
    dut_if.data_IN = d;
    dut_if.serv    = s;
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
    dut_if.push    = 1'b0;
    dut_if.serv    = 1'b0;
    dut_if.data_IN = '0;
  endtask

  task automatic fill_a();
    cyc(1'b1, w(8'hA1), 1'b0, 1'b1);
    cyc(1'b1, w(8'hA2), 1'b0, 1'b1);
    cyc(1'b1, w(8'hA3), 1'b0, 1'b1);
    cyc(1'b1, w(8'hA4), 1'b0, 1'b1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  // Scoreboard monitor: every serviced head must equal the oldest expected word.
  always @(negedge clk) begin
    if (!rst && dut_if.req && dut_if.serv) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected act=%0h exp=none", dut_if.data_OUT);
      end else begin
        chk("pop_data", dut_if.data_OUT, exp_q.pop_front());
      end
    end
  end

  initial begin
    dut_if.push    = 1'b0;
    dut_if.serv    = 1'b0;
    dut_if.data_IN = '0;
    #12 rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: asynchronous reset in the middle of a cycle with entries present.
    cyc(1'b1, w(8'h11), 1'b0, 1'b1);
    cyc(1'b1, w(8'h12), 1'b0, 1'b1);
    chk("count_pre_rst", DW'(dut_if.count), DW'(2));
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_req",   DW'(dut_if.req),     DW'(0));
    chk("rst_count", DW'(dut_if.count),   DW'(0));
    chk("rst_full",  DW'(dut_if.full),    DW'(0));
    chk("rst_data",  dut_if.data_OUT,     DW'(0));
    chk("rst_ovf",   DW'(dut_if.ovf_err), DW'(0));
    chk("rst_udf",   DW'(dut_if.udf_err), DW'(0));
    chk("rst_starve", DW'(dut_if.starve), DW'(0));
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // 2: fill to depth, then drain in order.
    cyc(1'b1, w(8'hA1), 1'b0, 1'b1);
    chk("lat_req",  DW'(dut_if.req), DW'(1));
    chk("lat_data", dut_if.data_OUT, w(8'hA1));
    cyc(1'b1, w(8'hA2), 1'b0, 1'b1);
    cyc(1'b1, w(8'hA3), 1'b0, 1'b1);
    cyc(1'b1, w(8'hA4), 1'b0, 1'b1);
    chk("fill_full",  DW'(dut_if.full),  DW'(1));
    chk("fill_count", DW'(dut_if.count), DW'(4));
    drain(4);
    chk("drain_req",   DW'(dut_if.req),   DW'(0));
    chk("drain_count", DW'(dut_if.count), DW'(0));
    chk("drain_data",  dut_if.data_OUT,   DW'(0));

    // 3: push and pop together while full, which wraps the pointers.
    fill_a();
    cyc(1'b1, w(8'hB5), 1'b1, 1'b1);
    chk("pp_count", DW'(dut_if.count),   DW'(4));
    chk("pp_full",  DW'(dut_if.full),    DW'(1));
    chk("pp_ovf",   DW'(dut_if.ovf_err), DW'(0));
    chk("pp_head",  dut_if.data_OUT,     w(8'hA2));
    drain(4);
    chk("pp_empty", DW'(dut_if.count), DW'(0));

    // 4: overflow drops the word, then underflow on an empty queue.
    fill_a();
    cyc(1'b1, w(8'hC6), 1'b0, 1'b0);
    chk("ovf_flag",  DW'(dut_if.ovf_err), DW'(1));
    chk("ovf_count", DW'(dut_if.count),   DW'(4));
    drain(4);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("udf_flag",   DW'(dut_if.udf_err), DW'(1));
    chk("udf_count",  DW'(dut_if.count),   DW'(0));
    chk("ovf_sticky", DW'(dut_if.ovf_err), DW'(1));

    // A push together with a pop at count 1 makes the new word the head.
    cyc(1'b1, w(8'hF1), 1'b0, 1'b1);
    cyc(1'b1, w(8'hF2), 1'b1, 1'b1);
    chk("c1_count", DW'(dut_if.count), DW'(1));
    chk("c1_head",  dut_if.data_OUT,   w(8'hF2));
    drain(1);

    // 5: the head holds steady while service is withheld.
    cyc(1'b1, w(8'hD7), 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, '0, 1'b0, 1'b0);
      chk("stall_req",    DW'(dut_if.req),    DW'(1));
      chk("stall_data",   dut_if.data_OUT,    w(8'hD7));
      chk("stall_starve", DW'(dut_if.starve), DW'(0));
    end
    drain(1);
    chk("stall_done_req", DW'(dut_if.req), DW'(0));

    // 6: starvation flag rises on the 15th waiting edge and clears on a pop.
    cyc(1'b1, w(8'hE8), 1'b0, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      cyc(1'b0, '0, 1'b0, 1'b0);
      chk($sformatf("starve_edge%0d", k), DW'(dut_if.starve), DW'(AGE_ON && (k == 15)));
    end
    drain(1);
    chk("starve_clear", DW'(dut_if.starve), DW'(0));
    chk("final_req",    DW'(dut_if.req),    DW'(0));

    chk("exp_q_empty", DW'(exp_q.size()), DW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
